// File: rtl/rate_fifo_if.sv
// Pacing inputs and status/data outputs of rate_fifo, bundled for port connection.
// The master side drives the pacing waves and observes the buffer; the slave side is the buffer itself.
interface rate_fifo_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              clk_1;
    logic              clk_2;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              unf;

    modport master (
        output clk_1, clk_2,
        input  data_out, data_valid, full, empty, count, ovf, unf
    );

    modport slave (
        input  clk_1, clk_2,
        output data_out, data_valid, full, empty, count, ovf, unf
    );
endinterface

// File: rtl/rate_fifo.sv
// Paced FIFO: rising edges of clk_1 push an incrementing sequence word and rising edges of clk_2 pop one.
// Overflow and underflow caused by the rate mismatch are flagged sticky until reset.
module rate_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    rate_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        wr_sync_q, rd_sync_q;
    logic              wr_tick, rd_tick;
    logic              wr_accept, rd_accept;
    logic              full, empty;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] gen_q, gen_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Bit 0 is s1, bit 1 is s2, bit 2 is s3; a tick is a fresh rise seen between s2 and s3.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sync_q <= '0;
            rd_sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_sync_q <= {wr_sync_q[1:0], bus.clk_1};
            rd_sync_q <= {rd_sync_q[1:0], bus.clk_2};
        end
    end

    assign wr_tick   = wr_sync_q[1] & ~wr_sync_q[2];
    assign rd_tick   = rd_sync_q[1] & ~rd_sync_q[2];

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign rd_accept = rd_tick & ~empty;
    assign wr_accept = wr_tick & (~full | rd_accept);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        gen_d    = gen_q;
        data_d   = data_q;
        valid_d  = rd_accept;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (rd_accept) begin
            data_d   = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            gen_d    = gen_q + 1'b1;
        end

        if (wr_accept && !rd_accept) begin
            count_d = count_q + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - 1'b1;
        end

        if (wr_tick && !wr_accept) ovf_d = 1'b1;
        if (rd_tick && empty)      unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gen_q    <= DATA_W'(1);
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            gen_q    <= gen_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gating guarantees no entry is read before written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= gen_q;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
endmodule

// File: tb/tb_rate_fifo.sv
// Bench for rate_fifo: a queue-based reference model predicts pops and status; a negedge monitor compares.
// Directed scenarios cover the boundary cases, followed by randomized pacing phases.
module tb_rate_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rate_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rate_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus a list of pending ticks, each due two edges after the rise is sampled.
    int                edge_n  = 0;
    bit                started = 1'b0;
    logic [DATA_W-1:0] m_fifo[$];
    logic [DATA_W-1:0] m_gen   = 1;
    logic [DATA_W-1:0] m_out   = '0;
    bit                m_valid = 1'b0;
    bit                m_ovf   = 1'b0;
    bit                m_unf   = 1'b0;
    bit                prev_1  = 1'b0;
    bit                prev_2  = 1'b0;
    int                wr_due[$];
    int                rd_due[$];
    logic [DATA_W-1:0] sb[$];
    bit                w_now, r_now, w_ok, r_ok;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_fifo.delete();
            wr_due.delete();
            rd_due.delete();
            m_gen   = 1;
            m_out   = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            prev_1  = 1'b0;
            prev_2  = 1'b0;
            started = 1'b1;
        end else begin
            w_now = (wr_due.size() > 0) && (wr_due[0] == edge_n);
            r_now = (rd_due.size() > 0) && (rd_due[0] == edge_n);
            if (w_now) void'(wr_due.pop_front());
            if (r_now) void'(rd_due.pop_front());
            r_ok = r_now && (m_fifo.size() > 0);
            w_ok = w_now && ((m_fifo.size() < DEPTH) || r_ok);
            if (r_now && !r_ok) m_unf = 1'b1;
            if (w_now && !w_ok) m_ovf = 1'b1;
            m_valid = r_ok;
            if (r_ok) begin
                m_out = m_fifo.pop_front();
                sb.push_back(m_out);
            end
            if (w_ok) begin
                m_fifo.push_back(m_gen);
                m_gen = m_gen + 1'b1;
            end
            if (bus.clk_1 && !prev_1) wr_due.push_back(edge_n + 2);
            if (bus.clk_2 && !prev_2) rd_due.push_back(edge_n + 2);
            prev_1 = bus.clk_1;
            prev_2 = bus.clk_2;
        end
    end

    logic [DATA_W-1:0] exp_word;

    always @(negedge clk) begin
        if (started) begin
            check("count",      bus.count,      m_fifo.size());
            check("full",       bus.full,       (m_fifo.size() == DEPTH));
            check("empty",      bus.empty,      (m_fifo.size() == 0));
            check("ovf",        bus.ovf,        m_ovf);
            check("unf",        bus.unf,        m_unf);
            check("data_valid", bus.data_valid, m_valid);
            check("data_out",   bus.data_out,   m_out);
            if (bus.data_valid === 1'b1) begin
                check("pop_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_word = sb.pop_front();
                    check("pop_word", bus.data_out, exp_word);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit w, input bit r, input int hi, input int lo);
        bus.clk_1 = w;
        bus.clk_2 = r;
        repeat (hi) @(negedge clk);
        bus.clk_1 = 1'b0;
        bus.clk_2 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    int wp, rp;

    initial begin
        bus.clk_1 = 1'b0;
        bus.clk_2 = 1'b0;
        rst       = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Three writes then three reads.
        repeat (3) pulse(1, 0, 2, 4);
        repeat (3) pulse(0, 1, 2, 4);

        // Nine writes: the ninth overflows; draining continues the sequence, then one underflowing read.
        repeat (9) pulse(1, 0, 2, 3);
        repeat (9) pulse(0, 1, 2, 3);
        pulse(1, 0, 2, 4);
        pulse(0, 1, 2, 4);

        // Simultaneous ticks while full, then while empty.
        repeat (8) pulse(1, 0, 1, 2);
        pulse(1, 1, 2, 4);
        repeat (8) pulse(0, 1, 1, 2);
        pulse(1, 1, 2, 4);
        pulse(0, 1, 2, 4);

        // Reset with five words held, clk_1 already high as reset releases.
        repeat (5) pulse(1, 0, 2, 3);
        rst       = 1'b1;
        bus.clk_1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse(1, 0, 2, 4);

        // Twenty narrow write/read pairs wrap both pointers.
        repeat (20) begin
            pulse(1, 0, 1, 1);
            pulse(0, 1, 1, 1);
        end
        idle(4);

        // Randomized pacing with different write/read densities.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin wp = 60; rp = 20; end
                1:       begin wp = 20; rp = 60; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 90; rp = 90; end
            endcase
            repeat (200) begin
                bus.clk_1 = ($urandom_range(0, 99) < wp);
                bus.clk_2 = ($urandom_range(0, 99) < rp);
                @(negedge clk);
            end
        end
        bus.clk_1 = 1'b0;
        bus.clk_2 = 1'b0;
        idle(8);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rate_fifo.md
# rate_fifo

Paced producer/consumer buffer directly downstream of the clock-divider stage. It takes the two divided square waves from the divider as pacing inputs: `clk_1` (fixed rate) paces writes and `clk_2` (programmable rate) paces reads. On each `clk_1` rising edge it pushes an internally generated sequence word into a small synchronous FIFO. On each `clk_2` rising edge it pops one word to the display/output logic, and it flags overflow and underflow caused by the rate mismatch.

## Interface
- `DATA_W`, 16, width of generated/stored words
- `DEPTH`, 8, FIFO entries; must be a power of two
- `ADDR_W`, 3, log2(`DEPTH`)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high; one clock; reset is synchronous and active-high
- `clk_1`  in  1  write pacing square wave from divider (treated as a level, not a clock)
- `clk_2`  in  1  read pacing square wave from divider (treated as a level, not a clock)
- `data_out`  out  DATA_W  last popped word; holds between pops
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `ovf`  out  1  sticky: write tick arrived while full and not simultaneously read
- `unf`  out  1  sticky: read tick arrived while empty

## Operation
- Pacing inputs pass through three flops each (s1→s2→s3). The tick is `s2 & ~s3`, so each input rising edge gives exactly one one-cycle tick. Falling edges are ignored.
- Generator register `gen`, DATA_W bits:
  - reset value 1.
  - on an accepted write: stores `gen`, then `gen <= gen + 1`, wrapping from 2^DATA_W−1 to 0.
  - a rejected write does not advance `gen`.
- Write accept = `wr_tick & (~full | rd_accept)`.
- Read accept = `rd_tick & ~empty`.
- Accepted write:
  - `mem[wr_ptr] <= gen`
  - `wr_ptr <= wr_ptr + 1`, modulo DEPTH.
- Accepted read:
  - `data_out <= mem[rd_ptr]`
  - `rd_ptr <= rd_ptr + 1`, modulo DEPTH
  - `data_valid <= 1` for exactly one cycle.
- Count update:
  - +1 on a write-only accept.
  - −1 on a read-only accept.
  - unchanged when both are accepted or neither is.
- `full` and `empty` are derived combinationally from `count`, never from pointer comparison.
- Boundary cases:
  - Full, both ticks: read then write both proceed; count stays DEPTH; `ovf` not set.
  - Empty, both ticks: read rejected and `unf` set; write proceeds; count becomes 1; no `data_valid`.
  - Full, write tick only: dropped; `ovf <= 1`; pointers and `gen` unchanged.
  - Empty, read tick only: `unf <= 1`; `data_out` holds.
- `ovf` and `unf` clear only on `rst`.
- Reset mid-operation discards all contents. Memory contents are don't-care after reset and are never read before being written.

## Timing
- Reset values:
  - `data_out` = 0, `data_valid` = 0
  - `count` = 0, `empty` = 1, `full` = 0
  - `ovf` = 0, `unf` = 0
  - pointers = 0, `gen` = 1
  - all sync flops = 0
- Latency: if edge k is the first `clk` edge sampling a pacing input high, the tick is high in the cycle after edge k+1. The FIFO/`data_out` update commits at edge k+2, and `data_valid` is high during the cycle following edge k+2.
- An input already high when reset deasserts produces one tick two cycles later.
- Back-to-back ticks are possible only if an input pulse is one cycle wide. Every tick is processed; there is no lost-tick window.
- Throughput: one write and one read per cycle maximum.

## Test plan
- Reset with both pacing inputs low, hold 5 cycles -> `empty`=1, `count`=0, `data_out`=0, `data_valid`=0, `ovf`=`unf`=0.
- Three `clk_1` rising edges, then three `clk_2` rising edges -> `count` goes 1,2,3 then 2,1,0; `data_out` sequence 1,2,3; each update commits 2 edges after the input rise is first sampled, with a one-cycle `data_valid` each.
- Nine `clk_1` edges with no reads (DEPTH=8) -> `full`=1 after the 8th; 9th dropped with `ovf`=1; the next read returns 1 and the one after returns 2, with no gap in the sequence.
- `clk_2` edge while empty -> `unf`=1, no `data_valid`, `data_out` unchanged. A following `clk_1` edge gives `count`=1, `unf` still 1.
- FIFO full, `clk_1` and `clk_2` rising on the same cycle -> `count` stays 8, `ovf` stays 0, `data_out` = oldest word. FIFO empty with simultaneous edges -> `count`=1, `unf`=1.
- `rst` asserted with `count`=5 -> next cycle `count`=0, `empty`=1. The first word written after that is 1 (`gen` restarted); pointer wrap is exercised over 20 write/read pairs with a continuous 1..20 sequence.
